// File: rtl/uart_hex_sender.sv
// Prints a captured VALUE as uppercase ASCII hex plus a terminator over the uart_tx handshake.
// Optional: define UART_HEX_SENDER_CRLF_EN for a CR LF terminator instead of a single space.
module uart_hex_sender #(
   parameter int VALUE_W  = 16,
   parameter int BUSY_TMO = 15
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               SEND,
   input  logic [VALUE_W-1:0] VALUE,
   output logic               READY,
   output logic               DONE,
   output logic               ERR,
   output logic               TX_START,
   output logic [7:0]         TX_DATA,
   input  logic               TX_BUSY
);

   localparam int DIGITS = VALUE_W / 4;
`ifdef UART_HEX_SENDER_CRLF_EN
   localparam int MSG_LEN = DIGITS + 2;
`else
   localparam int MSG_LEN = DIGITS + 1;
`endif
   localparam int IDX_W = $clog2(DIGITS + 2);
   localparam int CNT_W = $clog2(BUSY_TMO + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

   typedef enum logic [2:0] {
      IDLE, STRT, WBSY, WDONE, FIN, ABRT
   } state_t;

   state_t              state, nxt;
   logic [IDX_W-1:0]    idx, chr_idx;
   logic [CNT_W-1:0]    cnt;
   logic [VALUE_W-1:0]  shadow, chr_val;
   logic                ready_d, done_d, err_d, start_d;
   logic [7:0]          data_d;

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [7:0] msg_chr(
      input logic [VALUE_W-1:0] v,
      input logic [IDX_W-1:0]   i
   );
      logic [7:0] c;
      c = 8'h00;
      for (int d = 0; d < DIGITS; d++)
         if (i == IDX_W'(d)) c = hex_chr(v[VALUE_W-1-4*d -: 4]);
`ifdef UART_HEX_SENDER_CRLF_EN
      if (i == IDX_W'(DIGITS))     c = 8'h0D;
      if (i == IDX_W'(DIGITS + 1)) c = 8'h0A;
`else
      if (i == IDX_W'(DIGITS))     c = 8'h20;
`endif
      return c;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         READY    <= 1'b1;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         TX_START <= 1'b0;
         TX_DATA  <= 8'h00;
         idx      <= '0;
         cnt      <= '0;
         shadow   <= '0;
      end else begin
         state    <= nxt;
         READY    <= ready_d;
         DONE     <= done_d;
         ERR      <= err_d;
         TX_START <= start_d;
         TX_DATA  <= data_d;
         if (state == IDLE && SEND) begin
            shadow <= VALUE;
            idx    <= '0;
         end
         if (state == WDONE && !TX_BUSY && idx != LAST)
            idx <= idx + IDX_W'(1);
         if (state == STRT)
            cnt <= '0;
         else if (state == WBSY)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (SEND) nxt = STRT;
         STRT:    nxt = WBSY;
         WBSY: begin
            if (TX_BUSY)              nxt = WDONE;
            else if (cnt == TMO_LAST) nxt = ABRT;
         end
         WDONE:   if (!TX_BUSY) nxt = (idx == LAST) ? FIN : STRT;
         FIN:     nxt = IDLE;
         ABRT:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // The first character comes straight from VALUE since shadow loads on the same edge.
   always_comb begin
      ready_d = (nxt == IDLE);
      done_d  = (nxt == FIN);
      err_d   = (nxt == ABRT);
      start_d = (nxt == STRT);
      chr_val = (state == IDLE) ? VALUE : shadow;
      chr_idx = (state == IDLE) ? '0 : idx + IDX_W'(1);
      data_d  = start_d ? msg_chr(chr_val, chr_idx) : TX_DATA;
   end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender with a behavioural uart_tx BUSY model.
// Terminator expectations follow UART_HEX_SENDER_CRLF_EN.
module tb_uart_hex_sender;

   localparam int CPB      = 2;
   localparam int BUSY_LEN = 10 * CPB;
`ifdef UART_HEX_SENDER_CRLF_EN
   localparam int          TERM_N = 2;
   localparam logic [15:0] TERM   = 16'h0D0A;
`else
   localparam int          TERM_N = 1;
   localparam logic [15:0] TERM   = 16'h2000;
`endif
   localparam int MSG_N = 4 + TERM_N;

   logic        CLK, RST_N, SEND, READY, DONE, ERR, TX_START, TX_BUSY;
   logic [15:0] VALUE;
   logic [7:0]  TX_DATA;
   logic        tie0;

   int total = 0, bad = 0, cyc = 0;
   int n_start = 0, n_done = 0, n_err = 0, bcnt = 0;
   int s0, d0, e0, ts, k;
   logic [7:0] got[$];
   logic [7:0] prev_data;
   logic       prev_start = 1'b0;

   uart_hex_sender dut (
      .CLK(CLK), .RST_N(RST_N), .SEND(SEND), .VALUE(VALUE),
      .READY(READY), .DONE(DONE), .ERR(ERR),
      .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // uart_tx model: BUSY one cycle after START, held for a full 8N1 frame
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                     bcnt <= 0;
      else if (tie0)                  bcnt <= 0;
      else if (TX_START && bcnt == 0) bcnt <= BUSY_LEN;
      else if (bcnt != 0)             bcnt <= bcnt - 1;
   end
   assign TX_BUSY = (bcnt != 0);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST_N) begin
         if (TX_START) begin
            check("start_w", {31'b0, prev_start}, 32'd0);
            got.push_back(TX_DATA);
            n_start++;
         end
         if (TX_BUSY) check("data_hold", {24'b0, TX_DATA}, {24'b0, prev_data});
         if (DONE) n_done++;
         if (ERR)  n_err++;
      end
      prev_start = TX_START;
      prev_data  = TX_DATA;
   end

   task automatic send(input logic [15:0] v);
      @(negedge CLK);
      SEND  = 1'b1;
      VALUE = v;
      @(negedge CLK);
      SEND  = 1'b0;
   endtask

   task automatic wait_for(input bit want_err, input string tag);
      int n;
      n = 0;
      while (!(want_err ? ERR : DONE) && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_to"}, {31'b0, n < 2000}, 32'd1);
   endtask

   task automatic chk_msg(input string tag, input logic [31:0] dig);
      logic [7:0] e;
      check({tag, "_len"}, got.size(), MSG_N);
      for (int i = 0; i < MSG_N; i++) begin
         if (i < 4) e = dig[31-8*i -: 8];
         else       e = TERM[15-8*(i-4) -: 8];
         if (i < got.size())
            check($sformatf("%s_c%0d", tag, i), {24'b0, got[i]}, {24'b0, e});
      end
   endtask

   initial begin
      SEND  = 1'b0;
      VALUE = 16'h0;
      tie0  = 1'b0;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_ready", {31'b0, READY}, 1);
      check("rst_start", {31'b0, TX_START}, 0);
      check("rst_data", {24'b0, TX_DATA}, 0);
      check("rst_done", {31'b0, DONE}, 0);
      check("rst_err", {31'b0, ERR}, 0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("rel_ready", {31'b0, READY}, 1);

      // T1: 1A2F
      got.delete();
      d0 = n_done;
      send(16'h1A2F);
      check("t1_lat_start", {31'b0, TX_START}, 1);
      check("t1_lat_data", {24'b0, TX_DATA}, 32'h31);
      check("t1_busy_ready", {31'b0, READY}, 0);
      wait_for(1'b0, "t1");
      @(negedge CLK);
      check("t1_ready_after", {31'b0, READY}, 1);
      check("t1_done_w", {31'b0, DONE}, 0);
      chk_msg("t1", 32'h31413246);
      check("t1_ndone", n_done - d0, 1);

      // T2: 0000
      got.delete();
      send(16'h0000);
      wait_for(1'b0, "t2");
      @(negedge CLK);
      chk_msg("t2", 32'h30303030);

      // T3: SEND held, VALUE changed, SEND mid-message and in FIN
      got.delete();
      s0 = n_start;
      @(negedge CLK);
      SEND  = 1'b1;
      VALUE = 16'hFFFF;
      repeat (3) @(negedge CLK);
      SEND  = 1'b0;
      VALUE = 16'h1234;
      repeat (30) @(negedge CLK);
      SEND = 1'b1;
      repeat (2) @(negedge CLK);
      SEND = 1'b0;
      wait_for(1'b0, "t3");
      SEND = 1'b1;
      @(negedge CLK);
      SEND = 1'b0;
      check("t3_ready", {31'b0, READY}, 1);
      repeat (5) @(negedge CLK);
      chk_msg("t3", 32'h46464646);
      check("t3_starts", n_start - s0, MSG_N);
      check("t3_idle", {31'b0, READY}, 1);

      // T4: stuck transmitter, then restart
      tie0 = 1'b1;
      got.delete();
      s0 = n_start;
      d0 = n_done;
      e0 = n_err;
      send(16'h1234);
      ts = cyc;
      check("t4_start", {31'b0, TX_START}, 1);
      wait_for(1'b1, "t4");
      check("t4_err_lat", cyc - ts, 16);
      @(negedge CLK);
      check("t4_ready", {31'b0, READY}, 1);
      check("t4_err_w", {31'b0, ERR}, 0);
      check("t4_starts", n_start - s0, 1);
      check("t4_ndone", n_done - d0, 0);
      check("t4_nerr", n_err - e0, 1);
      tie0 = 1'b0;
      got.delete();
      send(16'hC0DE);
      wait_for(1'b0, "t4b");
      @(negedge CLK);
      chk_msg("t4b", 32'h43304445);

      // T5: reset during the third character
      got.delete();
      s0 = n_start;
      send(16'h5678);
      k = 0;
      while (n_start < s0 + 3 && k < 2000) begin
         @(negedge CLK);
         k++;
      end
      check("t5_to", {31'b0, k < 2000}, 1);
      repeat (5) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check("t5_rst_start", {31'b0, TX_START}, 0);
      check("t5_rst_data", {24'b0, TX_DATA}, 0);
      check("t5_rst_ready", {31'b0, READY}, 1);
      check("t5_rst_done", {31'b0, DONE}, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("t5_ready", {31'b0, READY}, 1);
      got.delete();
      send(16'hBEEF);
      check("t5_first", {24'b0, TX_DATA}, 32'h42);
      wait_for(1'b0, "t5");
      @(negedge CLK);
      chk_msg("t5", 32'h42454546);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
